// File: rtl/plot_pkg.sv
// Shared constants and state encoding for the pixel-port arbiter and its
// round-robin picker.
package plot_pkg;

    localparam int SCREEN_W    = 320;
    localparam int SCREEN_H    = 240;
    localparam int X_W_DEF     = 9;
    localparam int Y_W_DEF     = 8;
    localparam int COLOR_W_DEF = 3;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/plot_arbiter_if.sv
// Requester handshake bundle plus the vga_adapter pixel-write side.
// master: producers/environment, slave: the arbiter.
interface plot_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int X_W     = plot_pkg::X_W_DEF,
    parameter int Y_W     = plot_pkg::Y_W_DEF,
    parameter int COLOR_W = plot_pkg::COLOR_W_DEF
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_lock;
    logic [NUM_REQ*X_W-1:0]     req_x;
    logic [NUM_REQ*Y_W-1:0]     req_y;
    logic [NUM_REQ*COLOR_W-1:0] req_color;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       plot;
    logic [X_W-1:0]             X;
    logic [Y_W-1:0]             Y;
    logic [COLOR_W-1:0]         color;
    logic [ID_W-1:0]            grant_id;
    logic                       locked;

    modport master (
        output req_valid, req_lock, req_x, req_y, req_color,
        input  req_ready, plot, X, Y, color, grant_id, locked
    );

    modport slave (
        input  req_valid, req_lock, req_x, req_y, req_color,
        output req_ready, plot, X, Y, color, grant_id, locked
    );

endinterface

// File: rtl/plot_arbiter_rr_select.sv
// Combinational round-robin picker: first set request after i_last,
// wrapping around. Reusable for any N-way port share.
module rr_select #(
    parameter int N    = 3,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_last,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    int w_cand;

    // Scan candidates last+1 .. last+N, keep the first hit.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= N; k++) begin
            w_cand = (int'(i_last) + k) % N;
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = ID_W'(w_cand);
                o_grant[w_cand] = 1'b1;
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin arbiter with burst lock sharing the vga_adapter pixel port.
// Optional macro PLOT_ARBITER_CLIP_EN suppresses off-screen pixels.
import plot_pkg::*;

module plot_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int X_W          = X_W_DEF,
    parameter int Y_W          = Y_W_DEF,
    parameter int COLOR_W      = COLOR_W_DEF,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          reset,
    plot_arbiter_if.slave bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    arb_state_e         r_state, w_next;
    logic [ID_W-1:0]    r_last, r_grant_id, w_rr_idx, w_sel_idx;
    logic [NUM_REQ-1:0] w_rr_grant, w_ready;
    logic               w_rr_any, w_xfer, w_in_range;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_plot;
    logic [X_W-1:0]     r_x, w_sel_x;
    logic [Y_W-1:0]     r_y, w_sel_y;
    logic [COLOR_W-1:0] r_color, w_sel_color;

    rr_select #(.N(NUM_REQ), .ID_W(ID_W)) u_rr_select (
        .i_req   (bus.req_valid),
        .i_last  (r_last),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

    assign w_sel_x     = bus.req_x[w_sel_idx*X_W +: X_W];
    assign w_sel_y     = bus.req_y[w_sel_idx*Y_W +: Y_W];
    assign w_sel_color = bus.req_color[w_sel_idx*COLOR_W +: COLOR_W];

`ifdef PLOT_ARBITER_CLIP_EN
    assign w_in_range = (w_sel_x < X_W'(SCREEN_W)) && (w_sel_y < Y_W'(SCREEN_H));
`else
    assign w_in_range = 1'b1;
`endif

    // Grant selection, transfer detect and lock/release decisions.
    always_comb begin
        w_ready   = '0;
        w_sel_idx = r_grant_id;
        w_xfer    = 1'b0;
        w_next    = r_state;
        case (r_state)
            ARB: begin
                w_ready   = w_rr_grant;
                w_sel_idx = w_rr_idx;
                w_xfer    = w_rr_any;
                if (w_rr_any && bus.req_lock[w_rr_idx]) begin
                    w_next = LOCKED;
                end else begin
                    w_next = ARB;
                end
            end
            LOCKED: begin
                w_ready[r_grant_id] = 1'b1;
                w_xfer              = bus.req_valid[r_grant_id];
                if (w_xfer) begin
                    w_next = bus.req_lock[r_grant_id] ? LOCKED : ARB;
                end else if (!bus.req_lock[r_grant_id]) begin
                    w_next = ARB;
                end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    w_next = ARB;
                end else begin
                    w_next = LOCKED;
                end
            end
            default: begin
                w_next = ARB;
            end
        endcase
        // Nothing may be accepted while reset is held; it would be lost.
        if (reset) begin
            w_ready = '0;
            w_xfer  = 1'b0;
        end else begin
            w_ready = w_ready;
        end
    end

    // State register and idle-owner timeout counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ARB;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == LOCKED && !w_xfer && w_next == LOCKED) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Pointer, owner id and the registered pixel presented to the adapter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last     <= ID_W'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_plot     <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_color    <= '0;
        end else begin
            r_plot <= w_xfer && w_in_range;
            if (w_xfer) begin
                r_last     <= w_sel_idx;
                r_grant_id <= w_sel_idx;
                if (w_in_range) begin
                    r_x     <= w_sel_x;
                    r_y     <= w_sel_y;
                    r_color <= w_sel_color;
                end
            end
        end
    end

    assign bus.req_ready = w_ready;
    // Mask the strobe during reset so a pixel in flight never reaches the adapter.
    assign bus.plot      = r_plot & ~reset;
    assign bus.X         = r_x;
    assign bus.Y         = r_y;
    assign bus.color     = r_color;
    assign bus.grant_id  = r_grant_id;
    assign bus.locked    = (r_state == LOCKED);

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter (3 requesters, 320x240).
module tb_plot_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    plot_arbiter_if #(.NUM_REQ(3), .X_W(9), .Y_W(8), .COLOR_W(3)) bus ();

    plot_arbiter #(.NUM_REQ(3), .X_W(9), .Y_W(8), .COLOR_W(3), .LOCK_TIMEOUT(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
        bus.req_valid[i]         = v;
        bus.req_lock[i]          = l;
        bus.req_x[i*9 +: 9]      = x;
        bus.req_y[i*8 +: 8]      = y;
        bus.req_color[i*3 +: 3]  = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic       exp_plot;
        logic [8:0] exp_x;

        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_color = '0;

        // Reset values
        do_reset();
        check_eq("rst_plot", bus.plot, 0);
        check_eq("rst_x", bus.X, 0);
        check_eq("rst_y", bus.Y, 0);
        check_eq("rst_color", bus.color, 0);
        check_eq("rst_grant", bus.grant_id, 0);
        check_eq("rst_locked", bus.locked, 0);

        // Single requester 1, one-cycle latency
        set_req(1, 1'b1, 1'b0, 9'd10, 8'd20, 3'b101);
        #1 check_eq("r1_ready", bus.req_ready, 3'b010);
        @(posedge clock); #1;
        set_req(1, 1'b0, 1'b0, 9'd10, 8'd20, 3'b101);
        check_eq("r1_plot", bus.plot, 1);
        check_eq("r1_x", bus.X, 10);
        check_eq("r1_y", bus.Y, 20);
        check_eq("r1_color", bus.color, 5);
        check_eq("r1_grant", bus.grant_id, 1);
        @(posedge clock); #1;
        check_eq("r1_plot_idle", bus.plot, 0);
        check_eq("r1_x_hold", bus.X, 10);

        // All valid, no lock: rotation 0,1,2,0,1,2
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 9'(100 + i), 8'(i), 3'(i));
        for (int k = 0; k < 6; k++) begin
            #1 check_eq("rot_ready", bus.req_ready, 32'(1) << (k % 3));
            @(posedge clock); #1;
            check_eq("rot_plot", bus.plot, 1);
            check_eq("rot_grant", bus.grant_id, k % 3);
            check_eq("rot_x", bus.X, 100 + (k % 3));
        end
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0);

        // Locked burst by requester 2 while 0 and 1 wait
        for (int p = 0; p < 5; p++) begin
            set_req(2, 1'b1, (p < 4), 9'(200 + p), 8'd7, 3'd6);
            if (p == 1) begin
                set_req(0, 1'b1, 1'b0, 9'd50, 8'd1, 3'd1);
                set_req(1, 1'b1, 1'b0, 9'd60, 8'd2, 3'd2);
            end
            #1 check_eq("burst_ready", bus.req_ready, 3'b100);
            check_eq("burst_locked", bus.locked, (p > 0));
            @(posedge clock); #1;
            check_eq("burst_plot", bus.plot, 1);
            check_eq("burst_x", bus.X, 200 + p);
            check_eq("burst_grant", bus.grant_id, 2);
        end
        set_req(2, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0);
        #1 check_eq("post_burst_locked", bus.locked, 0);
        check_eq("post_burst_ready", bus.req_ready, 3'b001);
        @(posedge clock); #1;
        set_req(0, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0);
        set_req(1, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0);
        check_eq("post_burst_grant", bus.grant_id, 0);
        check_eq("post_burst_x", bus.X, 50);
        check_eq("post_burst_plot", bus.plot, 1);

        // Lock timeout: owner 0 idle with lock held, requester 1 waiting
        set_req(0, 1'b1, 1'b1, 9'd30, 8'd3, 3'd3);
        #1 check_eq("to_ready0", bus.req_ready, 3'b001);
        @(posedge clock); #1;
        set_req(0, 1'b0, 1'b1, 9'd30, 8'd3, 3'd3);
        set_req(1, 1'b1, 1'b0, 9'd77, 8'd8, 3'd2);
        #1 check_eq("to_locked", bus.locked, 1);
        check_eq("to_stall", bus.req_ready, 3'b001);
        for (int c = 1; c <= 64; c++) begin
            @(posedge clock); #1;
            check_eq("to_locked_cycle", bus.locked, (c < 64));
        end
        set_req(0, 1'b0, 1'b0, 9'd30, 8'd3, 3'd3);
        #1 check_eq("to_ready1", bus.req_ready, 3'b010);
        @(posedge clock); #1;
        set_req(1, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0);
        check_eq("to_grant", bus.grant_id, 1);
        check_eq("to_x", bus.X, 77);
        check_eq("to_plot", bus.plot, 1);

        // Reset on the cycle after a locked transfer
        set_req(0, 1'b1, 1'b1, 9'd40, 8'd4, 3'd4);
        #1 check_eq("mrst_ready", bus.req_ready, 3'b001);
        @(posedge clock); #1;
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0);
        #1 check_eq("mrst_plot_in_reset", bus.plot, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        check_eq("mrst_plot", bus.plot, 0);
        check_eq("mrst_locked", bus.locked, 0);
        check_eq("mrst_grant", bus.grant_id, 0);
        check_eq("mrst_x", bus.X, 0);
        @(posedge clock); #1;
        check_eq("mrst_plot_after", bus.plot, 0);

        // Off-screen pixel x=320
`ifdef PLOT_ARBITER_CLIP_EN
        exp_plot = 1'b0;
        exp_x    = 9'd0;
`else
        exp_plot = 1'b1;
        exp_x    = 9'd320;
`endif
        set_req(1, 1'b1, 1'b0, 9'd320, 8'd5, 3'd1);
        #1 check_eq("clip_ready", bus.req_ready, 3'b010);
        @(posedge clock); #1;
        set_req(1, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0);
        check_eq("clip_plot", bus.plot, exp_plot);
        check_eq("clip_x", bus.X, exp_x);
        check_eq("clip_grant", bus.grant_id, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
